// File: rtl/ram_group_reader.sv
// Streams cmd_len words striped across four RAM banks (word i -> bank i%4, row base+i/4 mod DEPTH).
// Latency: first dout_valid RD_LATENCY+1 cycles after command acceptance, then one word per cycle.
// Backpressure: reads are issued only while in-flight reads plus FIFO words fit the 4-entry output FIFO.
module ram_group_reader #(
    parameter int AWIDTH     = 7,
    parameter int DWIDTH     = 64,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [AWIDTH-1:0] cmd_base_i,
    input  logic [AWIDTH+2:0] cmd_len_i,
    output logic [AWIDTH-1:0] ram_0_addr0_o,
    output logic              ram_0_ce0_o,
    output logic              ram_0_we0_o,
    output logic [DWIDTH-1:0] ram_0_d0_o,
    input  logic [DWIDTH-1:0] ram_0_q0_i,
    output logic [AWIDTH-1:0] ram_1_addr0_o,
    output logic              ram_1_ce0_o,
    output logic              ram_1_we0_o,
    output logic [DWIDTH-1:0] ram_1_d0_o,
    input  logic [DWIDTH-1:0] ram_1_q0_i,
    output logic [AWIDTH-1:0] ram_2_addr0_o,
    output logic              ram_2_ce0_o,
    output logic              ram_2_we0_o,
    output logic [DWIDTH-1:0] ram_2_d0_o,
    input  logic [DWIDTH-1:0] ram_2_q0_i,
    output logic [AWIDTH-1:0] ram_3_addr0_o,
    output logic              ram_3_ce0_o,
    output logic              ram_3_we0_o,
    output logic [DWIDTH-1:0] ram_3_d0_o,
    input  logic [DWIDTH-1:0] ram_3_q0_i,
    output logic [DWIDTH-1:0] dout_data_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int         LW       = AWIDTH + 3;

    logic [1:0]        state_q, state_d;
    logic              armed_q;
    logic              zlen_q, zlen_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     iss_cnt_q, iss_cnt_d;
    logic [LW-1:0]     pop_cnt_q, pop_cnt_d;
    logic [AWIDTH-1:0] row_q, row_d;

    logic [RD_LATENCY-1:0] tag_vld_q;
    logic [1:0]            tag_bank_q [RD_LATENCY];

    logic [DWIDTH-1:0] fifo_mem_q [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        fifo_cnt_q;

    logic              accept, issue, push, pop, last_pop;
    logic [1:0]        bank;
    logic [3:0]        credit_used;
    logic [DWIDTH-1:0] q_sel;

    assign bank         = iss_cnt_q[1:0];
    assign cmd_ready_o  = armed_q && (state_q == ST_IDLE) && !zlen_q;
    assign accept       = cmd_valid_i && cmd_ready_o;
    assign dout_valid_o = (fifo_cnt_q != 3'd0);
    assign dout_data_o  = dout_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
    assign pop          = dout_valid_o && dout_ready_i;
    assign push         = tag_vld_q[RD_LATENCY-1];
    assign last_pop     = pop && (pop_cnt_q == len_q - LW'(1));
    assign done_o       = ((state_q == ST_DRAIN) && last_pop) || zlen_q;
    assign busy_o       = (state_q != ST_IDLE) || zlen_q;

    // A word popped this cycle frees its slot at the same edge the new read's tag enters the pipe,
    // so it counts as a returned credit; without that the stream would stall every fourth cycle.
    always_comb begin
        credit_used = {1'b0, fifo_cnt_q};
        for (int i = 0; i < RD_LATENCY; i++) begin
            credit_used = credit_used + 4'(tag_vld_q[i]);
        end
    end

    assign issue = (state_q == ST_ISSUE) && (iss_cnt_q != len_q) &&
                   (credit_used < (4'd4 + {3'b000, pop}));

    assign ram_0_addr0_o = row_q;
    assign ram_1_addr0_o = row_q;
    assign ram_2_addr0_o = row_q;
    assign ram_3_addr0_o = row_q;
    assign ram_0_ce0_o   = issue && (bank == 2'd0);
    assign ram_1_ce0_o   = issue && (bank == 2'd1);
    assign ram_2_ce0_o   = issue && (bank == 2'd2);
    assign ram_3_ce0_o   = issue && (bank == 2'd3);
    assign ram_0_we0_o   = 1'b0;
    assign ram_1_we0_o   = 1'b0;
    assign ram_2_we0_o   = 1'b0;
    assign ram_3_we0_o   = 1'b0;
    assign ram_0_d0_o    = '0;
    assign ram_1_d0_o    = '0;
    assign ram_2_d0_o    = '0;
    assign ram_3_d0_o    = '0;

    always_comb begin
        case (tag_bank_q[RD_LATENCY-1])
            2'd0:    q_sel = ram_0_q0_i;
            2'd1:    q_sel = ram_1_q0_i;
            2'd2:    q_sel = ram_2_q0_i;
            default: q_sel = ram_3_q0_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        iss_cnt_d = iss_cnt_q;
        pop_cnt_d = pop_cnt_q;
        row_d     = row_q;
        zlen_d    = 1'b0;
        if (pop) begin
            pop_cnt_d = pop_cnt_q + LW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d     = cmd_len_i;
                    row_d     = cmd_base_i;
                    iss_cnt_d = '0;
                    pop_cnt_d = '0;
                    if (cmd_len_i == '0) begin
                        zlen_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    iss_cnt_d = iss_cnt_q + LW'(1);
                    if (bank == 2'd3) begin
                        row_d = (row_q == AWIDTH'(DEPTH - 1)) ? '0 : row_q + AWIDTH'(1);
                    end
                    if (iss_cnt_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            zlen_q    <= 1'b0;
            len_q     <= '0;
            iss_cnt_q <= '0;
            pop_cnt_q <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            zlen_q    <= zlen_d;
            len_q     <= len_d;
            iss_cnt_q <= iss_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            row_q     <= row_d;
        end
    end

    // Tag pipe mirrors the RAM read path so the landing word is captured from the right bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_bank_q[i] <= 2'd0;
            end
        end else begin
            tag_vld_q[0]  <= issue;
            tag_bank_q[0] <= bank;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_bank_q[i] <= tag_bank_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_cnt_q <= fifo_cnt_q + 3'(push) - 3'(pop);
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being read out this cycle.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= q_sel;
        end
    end

endmodule

// File: tb/tb_ram_group_reader.sv
// Directed bench for ram_group_reader: banks hold 1000*k + row and answer RD_LATENCY cycles after ce0.
// Outputs are sampled 2 time units after each rising edge; inputs change just after the edge.
module tb_ram_group_reader;

    localparam int AW = 7;
    localparam int DW = 64;
    localparam logic [DW-1:0] BAD = 64'hBADBADBAD;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_base;
    logic [AW+2:0]     cmd_len;
    logic [3:0][AW-1:0] addr;
    logic [3:0]        ce;
    logic [3:0]        we;
    logic [3:0][DW-1:0] d;
    logic [3:0][DW-1:0] q;
    logic [DW-1:0]     dout_data;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    ram_group_reader dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
        .ram_0_addr0_o(addr[0]), .ram_0_ce0_o(ce[0]), .ram_0_we0_o(we[0]), .ram_0_d0_o(d[0]), .ram_0_q0_i(q[0]),
        .ram_1_addr0_o(addr[1]), .ram_1_ce0_o(ce[1]), .ram_1_we0_o(we[1]), .ram_1_d0_o(d[1]), .ram_1_q0_i(q[1]),
        .ram_2_addr0_o(addr[2]), .ram_2_ce0_o(ce[2]), .ram_2_we0_o(we[2]), .ram_2_d0_o(d[2]), .ram_2_q0_i(q[2]),
        .ram_3_addr0_o(addr[3]), .ram_3_ce0_o(ce[3]), .ram_3_we0_o(we[3]), .ram_3_d0_o(d[3]), .ram_3_q0_i(q[3]),
        .dout_data_o(dout_data), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready),
        .busy_o(busy), .done_o(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: address registered, RAM, output register; non-enabled reads return a poison word.
    logic [DW-1:0] pipe [4][3];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            pipe[k][0] <= ce[k] ? 64'(1000 * k + int'(addr[k])) : BAD;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign q[0] = pipe[0][2];
    assign q[1] = pipe[1][2];
    assign q[2] = pipe[2][2];
    assign q[3] = pipe[3][2];

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int acc_cyc, first_vld, done_cyc, done_cnt, issued, popped, max_inflight, ce_seen, vld_seen, stall_n;
    bit multi_ce, busy_drop, stall_prev, s_ready;
    logic [DW-1:0] stall_dat;
    logic [DW-1:0] got[$];
    int got_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] gw(input int i);
        return (i < got.size()) ? got[i] : 64'hx;
    endfunction

    function automatic int gc(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1000;
    endfunction

    task automatic clear_trk();
        acc_cyc = -1; first_vld = -1; done_cyc = -1; done_cnt = 0;
        issued = 0; popped = 0; max_inflight = 0; ce_seen = 0; vld_seen = 0; stall_n = 0;
        multi_ce = 1'b0; busy_drop = 1'b0; stall_prev = 1'b0;
        got.delete();
        got_cyc.delete();
    endtask

    // Observe one cycle, then advance past the next rising edge.
    task automatic step();
        int ce_n;
        #1;
        ce_n = $countones(ce);
        if (ce_n > 1) multi_ce = 1'b1;
        issued += ce_n;
        ce_seen += ce_n;
        if (stall_prev) begin
            stall_n++;
            chk("stall_valid", 64'(dout_valid), 64'd1);
            chk("stall_data", dout_data, stall_dat);
        end
        stall_prev = dout_valid && !dout_ready;
        stall_dat = dout_data;
        if (dout_valid) begin
            vld_seen++;
            if (first_vld < 0) first_vld = cyc_n;
        end
        if (dout_valid && dout_ready) begin
            got.push_back(dout_data);
            got_cyc.push_back(cyc_n);
            popped++;
        end
        if (issued - popped > max_inflight) max_inflight = issued - popped;
        if (acc_cyc >= 0 && cyc_n > acc_cyc && done_cnt == 0 && !busy) busy_drop = 1'b1;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc_n;
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc_n;
        s_ready = cmd_ready;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_cmd(input int base, input int len, input bit toggle, input int budget);
        int k;
        clear_trk();
        cmd_base = AW'(base);
        cmd_len = 10'(len);
        cmd_valid = 1'b1;
        dout_ready = 1'b1;
        step();
        chk("cmd_accepted", 64'(s_ready), 64'd1);
        cmd_valid = 1'b0;
        k = 1;
        while (done_cnt == 0 && k < budget) begin
            dout_ready = toggle ? (k % 3 == 0) : 1'b1;
            step();
            k++;
        end
        dout_ready = 1'b1;
        repeat (3) step();
        chk("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    int exp1 [8]  = '{0, 1000, 2000, 3000, 1, 1001, 2001, 3001};
    int exp2 [12] = '{126, 1126, 2126, 3126, 127, 1127, 2127, 3127, 0, 1000, 2000, 3000};
    int exp6 [4]  = '{10, 1010, 2010, 3010};

    initial begin
        int k;
        cmd_valid = 1'b0;
        cmd_base = '0;
        cmd_len = '0;
        dout_ready = 1'b0;
        rst_n = 1'b1;
        clear_trk();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_cmd_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_ce", 64'(ce), 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_before_edge", 64'(s_ready), 64'd0);
        step();
        chk("ready_after_edge", 64'(s_ready), 64'd1);

        // Basic stripe, base 0, full rate.
        run_cmd(0, 8, 1'b0, 60);
        chk("t1_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("t1_word", gw(i), 64'(exp1[i]));
        // Acceptance edge closes cycle acc_cyc; the FIFO fills RD_LATENCY+1 edges later.
        chk("t1_first_latency", 64'(first_vld - acc_cyc), 64'd5);
        chk("t1_consecutive", 64'(gc(7) - gc(0)), 64'd7);
        chk("t1_done_with_last", 64'(done_cyc), 64'(gc(7)));
        chk("t1_ce_count", 64'(ce_seen), 64'd8);
        chk("t1_one_ce", 64'(multi_ce), 64'd0);
        chk("t1_busy_held", 64'(busy_drop), 64'd0);
        chk("t1_we_zero", 64'(we), 64'd0);
        chk("t1_d_zero", d[0] | d[1] | d[2] | d[3], 64'd0);
        chk("t1_idle_ready", 64'(cmd_ready), 64'd1);

        // Row wrap 127 -> 0.
        run_cmd(126, 12, 1'b0, 60);
        chk("t2_count", 64'(got.size()), 64'd12);
        for (int i = 0; i < 12; i++) chk("t2_word", gw(i), 64'(exp2[i]));

        // Stalling sink, ready 1,0,0 repeating.
        run_cmd(3, 16, 1'b1, 200);
        chk("t3_count", 64'(got.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk("t3_word", gw(i), 64'(1000 * (i % 4) + 3 + i / 4));
        chk("t3_inflight_le4", 64'(max_inflight <= 4), 64'd1);
        chk("t3_stalls_seen", 64'(stall_n > 0), 64'd1);
        chk("t3_one_ce", 64'(multi_ce), 64'd0);

        // Zero-length command.
        run_cmd(9, 0, 1'b0, 10);
        chk("t4_done_delay", 64'(done_cyc - acc_cyc), 64'd1);
        chk("t4_no_ce", 64'(ce_seen), 64'd0);
        chk("t4_no_valid", 64'(vld_seen), 64'd0);

        // Full 512-word sweep from base 5.
        run_cmd(5, 512, 1'b0, 700);
        chk("t5_count", 64'(got.size()), 64'd512);
        for (int i = 0; i < 512; i++) chk("t5_word", gw(i), 64'(1000 * (i % 4) + (5 + i / 4) % 128));
        chk("t5_last_word", gw(511), 64'd3004);
        chk("t5_consecutive", 64'(gc(511) - gc(0)), 64'd511);
        chk("t5_first_latency", 64'(first_vld - acc_cyc), 64'd5);
        chk("t5_busy_held", 64'(busy_drop), 64'd0);
        chk("t5_inflight_le4", 64'(max_inflight <= 4), 64'd1);

        // Reset in the middle of a 20-word transfer, then a fresh 4-word command.
        clear_trk();
        cmd_base = '0;
        cmd_len = 10'd20;
        cmd_valid = 1'b1;
        dout_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        k = 0;
        while (got.size() < 5 && k < 60) begin
            step();
            k++;
        end
        chk("t6_words_before_rst", 64'(got.size()), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(dout_valid), 64'd0);
        chk("t6_rst_ce", 64'(ce), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_ready", 64'(cmd_ready), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        run_cmd(10, 4, 1'b0, 40);
        chk("t6_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t6_word", gw(i), 64'(exp6[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
